// File: rtl/alu_pkg.sv
// Shared ALU encodings used by the datapath arithmetic units.
package alu_pkg;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/cla_block.sv
// BLK-bit carry-lookahead block: flattened generate/propagate carries,
// also exposing the carry into the top bit for overflow detection.
module cla_block #(
    parameter int unsigned BLK = 8
) (
    input  logic [BLK-1:0] a,
    input  logic [BLK-1:0] b,
    input  logic           cin,
    output logic [BLK-1:0] sum,
    output logic           cout,
    output logic           c_msb
);

    logic [BLK-1:0] g;
    logic [BLK-1:0] p;
    logic [BLK:0]   c;
    logic           acc;
    logic           pp;

    // c[i+1] = g[i] | p[i]g[i-1] | ... | p[i..0]cin, each term built independently
    always_comb begin
        g    = a & b;
        p    = a ^ b;
        c    = '0;
        acc  = 1'b0;
        pp   = 1'b0;
        c[0] = cin;
        for (int i = 0; i < int'(BLK); i++) begin
            acc = g[i];
            pp  = p[i];
            for (int j = i - 1; j >= 0; j--) begin
                acc = acc | (pp & g[j]);
                pp  = pp & p[j];
            end
            c[i+1] = acc | (pp & cin);
        end
    end

    assign sum   = p ^ c[BLK-1:0];
    assign cout  = c[BLK];
    assign c_msb = c[BLK-1];

endmodule

// File: rtl/pipelined_cla_adder.sv
// Pipelined carry-lookahead adder/subtractor: one BLK-bit block per stage,
// inter-block carry registered, valid/ready handshake with global stall.
module pipelined_cla_adder
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned BLK   = 8,
    parameter int unsigned TAGW  = 4
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_sub,
    input  logic [TAGW-1:0]  in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_ovf,
    output logic [TAGW-1:0]  out_tag
);

    localparam int unsigned NSTG = WIDTH / BLK;
    localparam int unsigned NB   = (NSTG > 1) ? NSTG - 1 : 1;

    if (WIDTH % BLK != 0) begin : g_width_check
        $error("pipelined_cla_adder: WIDTH must be a multiple of BLK");
    end

    // Per-stage registers; data_q carries finished low sum bits plus untouched upper A bits
    logic [NSTG-1:0]  valid_q;
    logic [NSTG-1:0]  carry_q;
    logic [WIDTH-1:0] data_q [NSTG];
    logic [WIDTH-1:0] b_q    [NB];
    logic [TAGW-1:0]  tag_q  [NSTG];
    logic             ovf_q;

    logic             adv;
    logic [NSTG-1:0]  src_valid;
    logic [NSTG-1:0]  src_cin;
    logic [NSTG-1:0]  blk_cout;
    logic             blk_cmsb [NSTG];
    logic [WIDTH-1:0] src_data [NSTG];
    logic [WIDTH-1:0] src_b    [NSTG];
    logic [WIDTH-1:0] data_nxt [NSTG];
    logic [TAGW-1:0]  src_tag  [NSTG];
    logic [BLK-1:0]   blk_sum  [NSTG];

    assign adv      = !valid_q[NSTG-1] || out_ready;
    assign in_ready = adv;

    for (genvar k = 0; k < int'(NSTG); k++) begin : g_stage
        localparam logic [WIDTH-1:0] MASK = WIDTH'({BLK{1'b1}}) << (k * BLK);

        // Stage 0 takes the new op (B pre-inverted for subtract); later stages take the previous stage
        if (k == 0) begin : g_src
            assign src_valid[k] = in_valid;
            assign src_data[k]  = in_a;
            assign src_b[k]     = in_b ^ {WIDTH{in_sub == OP_SUB}};
            assign src_cin[k]   = (in_sub == OP_SUB);
            assign src_tag[k]   = in_tag;
        end else begin : g_src
            assign src_valid[k] = valid_q[k-1];
            assign src_data[k]  = data_q[k-1];
            assign src_b[k]     = b_q[k-1];
            assign src_cin[k]   = carry_q[k-1];
            assign src_tag[k]   = tag_q[k-1];
        end

        cla_block #(.BLK(BLK)) u_cla (
            .a     (src_data[k][k*BLK +: BLK]),
            .b     (src_b[k][BLK-1:0]),
            .cin   (src_cin[k]),
            .sum   (blk_sum[k]),
            .cout  (blk_cout[k]),
            .c_msb (blk_cmsb[k])
        );

        assign data_nxt[k] = (src_data[k] & ~MASK) | (WIDTH'(blk_sum[k]) << (k * BLK));
    end

    // Pipeline registers: everything holds on stall; invalid stages keep their data
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            valid_q <= '0;
            carry_q <= '0;
            ovf_q   <= 1'b0;
            for (int k = 0; k < int'(NSTG); k++) begin
                data_q[k] <= '0;
                tag_q[k]  <= '0;
            end
            for (int k = 0; k < int'(NB); k++) begin
                b_q[k] <= '0;
            end
        end else if (adv) begin
            valid_q <= src_valid;
            for (int k = 0; k < int'(NSTG); k++) begin
                if (src_valid[k]) begin
                    data_q[k]  <= data_nxt[k];
                    carry_q[k] <= blk_cout[k];
                    tag_q[k]   <= src_tag[k];
                end
            end
            for (int k = 0; k < int'(NSTG) - 1; k++) begin
                if (src_valid[k]) begin
                    b_q[k] <= src_b[k] >> BLK;
                end
            end
            if (src_valid[NSTG-1]) begin
                ovf_q <= blk_cmsb[NSTG-1] ^ blk_cout[NSTG-1];
            end
        end
    end

    assign out_valid = valid_q[NSTG-1];
    assign out_sum   = data_q[NSTG-1];
    assign out_cout  = carry_q[NSTG-1];
    assign out_ovf   = ovf_q;
    assign out_tag   = tag_q[NSTG-1];

endmodule

// File: tb/tb_pipelined_cla_adder.sv
// Directed and randomised checks of pipelined_cla_adder at WIDTH=32, BLK=8.
module tb_pipelined_cla_adder;

    logic        clock = 1'b0;
    logic        resetn;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic        in_sub;
    logic [3:0]  in_tag;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_sum;
    logic        out_cout;
    logic        out_ovf;
    logic [3:0]  out_tag;

    int checks   = 0;
    int failures = 0;

    always #5 clock = ~clock;

    pipelined_cla_adder #(.WIDTH(32), .BLK(8), .TAGW(4)) dut (
        .clock     (clock),
        .resetn    (resetn),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_sub    (in_sub),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_cout  (out_cout),
        .out_ovf   (out_ovf),
        .out_tag   (out_tag)
    );

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Present one op into an empty pipe and wait (bounded) for its result.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic sub,
                          input logic [3:0] tag, output logic [31:0] sum, output logic cout,
                          output logic ovf, output logic [3:0] rtag, output int lat);
        out_ready = 1'b1;
        in_a      = a;
        in_b      = b;
        in_sub    = sub;
        in_tag    = tag;
        in_valid  = 1'b1;
        step();
        in_valid = 1'b0;
        lat      = 1;
        while (!out_valid && lat < 20) begin
            step();
            lat++;
        end
        sum  = out_sum;
        cout = out_cout;
        ovf  = out_ovf;
        rtag = out_tag;
        if (!out_valid) lat = -1;
        step();
    endtask

    task automatic test_reset();
        logic [31:0] s;
        logic        c;
        logic        o;
        logic [3:0]  t;
        int          lat;
        resetn    = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_sub    = 1'b0;
        in_tag    = '0;
        repeat (3) step();
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_out_valid: got %b expected 0", out_valid);
        end
        checks++;
        if (out_sum !== 32'h0) begin
            failures++;
            $display("FAIL reset_out_sum: got %h expected 00000000", out_sum);
        end
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_in_ready: got %b expected 1", in_ready);
        end
        checks++;
        if ({out_cout, out_ovf, out_tag} !== 6'b0) begin
            failures++;
            $display("FAIL reset_flags_tag: got %b expected 000000", {out_cout, out_ovf, out_tag});
        end
        resetn = 1'b1;
        step();
        run_op(32'd1, 32'd2, 1'b0, 4'h3, s, c, o, t, lat);
        checks++;
        if (s !== 32'h3) begin
            failures++;
            $display("FAIL add_1_2_sum: got %h expected 00000003", s);
        end
        checks++;
        if ({c, o, t} !== {1'b0, 1'b0, 4'h3}) begin
            failures++;
            $display("FAIL add_1_2_flags: got cout=%b ovf=%b tag=%h expected 0 0 3", c, o, t);
        end
        checks++;
        if (lat !== 4) begin
            failures++;
            $display("FAIL add_1_2_latency: got %0d expected 4", lat);
        end
    endtask

    task automatic test_carry_ripple_and_subtract();
        logic [31:0] va [5];
        logic [31:0] vb [5];
        logic [31:0] vs [5];
        logic        vsub [5];
        logic        vc [5];
        logic        vo [5];
        logic [31:0] s;
        logic        c;
        logic        o;
        logic [3:0]  t;
        int          lat;
        va = '{32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'd5,        32'h8000_0000, 32'd9};
        vb = '{32'h0000_0001, 32'h0000_0001, 32'd7,        32'd1,         32'd9};
        vsub = '{1'b0,        1'b0,          1'b1,         1'b1,          1'b1};
        vs = '{32'h0000_0000, 32'h8000_0000, 32'hFFFF_FFFE, 32'h7FFF_FFFF, 32'h0};
        vc = '{1'b1,          1'b0,          1'b0,         1'b1,          1'b1};
        vo = '{1'b0,          1'b1,          1'b0,         1'b1,          1'b0};
        for (int i = 0; i < 5; i++) begin
            run_op(va[i], vb[i], vsub[i], 4'(i + 8), s, c, o, t, lat);
            checks++;
            if (s !== vs[i]) begin
                failures++;
                $display("FAIL arith_sum[%0d]: got %h expected %h", i, s, vs[i]);
            end
            checks++;
            if ({c, o, t} !== {vc[i], vo[i], 4'(i + 8)}) begin
                failures++;
                $display("FAIL arith_flags[%0d]: got cout=%b ovf=%b tag=%h expected %b %b %h",
                         i, c, o, t, vc[i], vo[i], 4'(i + 8));
            end
            checks++;
            if (lat !== 4) begin
                failures++;
                $display("FAIL arith_latency[%0d]: got %0d expected 4", i, lat);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] va [8];
        logic [31:0] vb [8];
        logic [31:0] vs [8];
        logic        vsub [8];
        logic        vc [8];
        logic        vo [8];
        logic [37:0] held;
        bit          hold = 0;
        bit          acc;
        int          sent = 0;
        int          got  = 0;
        int          cyc  = 0;
        va = '{32'h10, 32'hFF, 32'hFFFF, 32'h00FF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000, 32'h100, 32'h0};
        vb = '{32'h20, 32'h01, 32'h0001, 32'h0000_0001, 32'hFFFF_FFFF, 32'h8000_0000, 32'h001, 32'h1};
        vsub = '{1'b0, 1'b0,   1'b0,     1'b0,          1'b0,          1'b0,          1'b1,    1'b1};
        vs = '{32'h30, 32'h100, 32'h1_0000, 32'h0100_0000, 32'hFFFF_FFFE, 32'h0, 32'hFF, 32'hFFFF_FFFF};
        vc = '{1'b0,   1'b0,    1'b0,       1'b0,          1'b1,          1'b1,  1'b1,  1'b0};
        vo = '{1'b0,   1'b0,    1'b0,       1'b0,          1'b0,          1'b1,  1'b0,  1'b0};
        while (got < 8 && cyc < 200) begin
            out_ready = (cyc % 3 == 0);
            in_valid  = (sent < 8);
            if (sent < 8) begin
                in_a   = va[sent];
                in_b   = vb[sent];
                in_sub = vsub[sent];
                in_tag = 4'(sent);
            end
            #1;
            checks++;
            if (in_ready !== !(out_valid && !out_ready)) begin
                failures++;
                $display("FAIL b2b_in_ready cyc %0d: got %b expected %b", cyc, in_ready,
                         !(out_valid && !out_ready));
            end
            if (hold) begin
                checks++;
                if ({out_valid, out_tag, out_sum} !== held) begin
                    failures++;
                    $display("FAIL b2b_stall_stable cyc %0d: got %h expected %h", cyc,
                             {out_valid, out_tag, out_sum}, held);
                end
            end
            if (out_valid && out_ready) begin
                checks++;
                if ({out_tag, out_sum, out_cout, out_ovf} !== {4'(got), vs[got], vc[got], vo[got]}) begin
                    failures++;
                    $display("FAIL b2b_result[%0d]: got tag=%h sum=%h c=%b v=%b expected %h %h %b %b",
                             got, out_tag, out_sum, out_cout, out_ovf, 4'(got), vs[got], vc[got], vo[got]);
                end
                got++;
            end
            hold = out_valid && !out_ready;
            held = {out_valid, out_tag, out_sum};
            acc  = in_valid && in_ready;
            step();
            if (acc) sent++;
            cyc++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        checks++;
        if (got !== 8) begin
            failures++;
            $display("FAIL b2b_count: got %0d results expected 8", got);
        end
    endtask

    task automatic test_reset_midflight();
        logic [31:0] s;
        logic        c;
        logic        o;
        logic [3:0]  t;
        int          lat;
        int          extra = 0;
        out_ready = 1'b1;
        in_sub    = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_a     = 32'(i + 100);
            in_b     = 32'd1;
            in_tag   = 4'(i + 1);
            step();
        end
        in_valid = 1'b0;
        resetn   = 1'b0;
        #1;
        checks++;
        if ({out_valid, in_ready, out_sum} !== {1'b0, 1'b1, 32'h0}) begin
            failures++;
            $display("FAIL midreset_clear: got valid=%b ready=%b sum=%h expected 0 1 00000000",
                     out_valid, in_ready, out_sum);
        end
        step();
        resetn = 1'b1;
        run_op(32'h1234_5678, 32'h1111_1111, 1'b0, 4'hA, s, c, o, t, lat);
        checks++;
        if ({t, s, c, o} !== {4'hA, 32'h2345_6789, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL midreset_result: got tag=%h sum=%h c=%b v=%b expected a 23456789 0 0",
                     t, s, c, o);
        end
        checks++;
        if (lat !== 4) begin
            failures++;
            $display("FAIL midreset_latency: got %0d expected 4", lat);
        end
        for (int i = 0; i < 8; i++) begin
            if (out_valid) extra++;
            step();
        end
        checks++;
        if (extra !== 0) begin
            failures++;
            $display("FAIL midreset_stale: got %0d extra valid cycles expected 0", extra);
        end
    endtask

    task automatic test_random();
        logic [37:0] q [$];
        logic [37:0] want;
        logic [31:0] bb;
        logic [32:0] full;
        logic        ovf;
        for (int cyc = 0; cyc < 3000 + 20; cyc++) begin
            if (cyc < 3000) begin
                out_ready = ($urandom_range(0, 3) != 0);
                in_valid  = 1'($urandom_range(0, 1));
                in_a      = $urandom;
                in_b      = $urandom;
                in_sub    = 1'($urandom_range(0, 1));
                in_tag    = 4'($urandom);
            end else begin
                out_ready = 1'b1;
                in_valid  = 1'b0;
            end
            #1;
            if (out_valid && out_ready) begin
                checks++;
                if (q.size() == 0) begin
                    failures++;
                    $display("FAIL rand_unexpected cyc %0d: got tag=%h sum=%h expected none",
                             cyc, out_tag, out_sum);
                end else begin
                    want = q.pop_front();
                    if ({out_tag, out_cout, out_ovf, out_sum} !== want) begin
                        failures++;
                        $display("FAIL rand_result cyc %0d: got %h expected %h", cyc,
                                 {out_tag, out_cout, out_ovf, out_sum}, want);
                    end
                end
            end
            if (in_valid && in_ready) begin
                bb   = in_b ^ {32{in_sub}};
                full = {1'b0, in_a} + {1'b0, bb} + 33'(in_sub);
                ovf  = (in_a[31] == bb[31]) && (full[31] != in_a[31]);
                q.push_back({in_tag, full[32], ovf, full[31:0]});
            end
            step();
        end
        checks++;
        if (q.size() !== 0) begin
            failures++;
            $display("FAIL rand_drain: got %0d results outstanding expected 0", q.size());
        end
    endtask

    initial begin
        test_reset();
        test_carry_ripple_and_subtract();
        test_back_to_back();
        test_reset_midflight();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
